// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The build macro MEM_ARB_RR_EN selects round-robin idle arbitration (see mem_arb_grant).
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int PORT_LSU = 0;
    localparam int PORT_IF  = 1;

    // One-hot grant vector, bit index = port number.
    typedef logic [1:0] grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the arbiter: LSU (port 0, read/write, lockable)
// and IF (port 1, read-only). master = requesters, slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 10
);
    logic             p0_valid;
    logic             p0_ready;
    logic             p0_we;
    logic             p0_lock;
    logic [AW-1:0]    p0_addr;
    logic [WIDTH-1:0] p0_wdata;
    logic             p0_rvalid;
    logic [WIDTH-1:0] p0_rdata;

    logic             p1_valid;
    logic             p1_ready;
    logic [AW-1:0]    p1_addr;
    logic             p1_rvalid;
    logic [WIDTH-1:0] p1_rdata;

    modport master (
        output p0_valid, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata,
        output p1_valid, p1_addr,
        input  p1_ready, p1_rvalid, p1_rdata
    );

    modport slave (
        input  p0_valid, p0_we, p0_lock, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata,
        input  p1_valid, p1_addr,
        output p1_ready, p1_rvalid, p1_rdata
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant select plus the arbitration history registers.
// Default: fixed priority to the LSU with an IF starvation counter.
// MEM_ARB_RR_EN defined: round-robin between the two ports when idle.
// While LOCKED only the LSU may be granted in both modes.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  arb_state_t state,
    input  logic       p0_valid,
    input  logic       p1_valid,
    output grant_t     grant
);

    grant_t grant_raw;

`ifdef MEM_ARB_RR_EN

    // Port granted most recently; IF is treated as last after reset.
    logic rr_last;

    // Round-robin select: on conflict the port that did not go last wins.
    always_comb begin
        grant_raw = '0;
        if (state == LOCKED) begin
            grant_raw[PORT_LSU] = p0_valid;
        end else if (p0_valid && p1_valid) begin
            if (rr_last) grant_raw[PORT_LSU] = 1'b1;
            else         grant_raw[PORT_IF]  = 1'b1;
        end else begin
            grant_raw[PORT_LSU] = p0_valid;
            grant_raw[PORT_IF]  = p1_valid;
        end
    end

    // Remember which port was accepted last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= 1'b1;
        end else if (grant[PORT_LSU]) begin
            rr_last <= 1'b0;
        end else if (grant[PORT_IF]) begin
            rr_last <= 1'b1;
        end
    end

`else

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_cnt;

    // Fixed priority to the LSU unless the IF has waited MAX_WAIT cycles.
    always_comb begin
        grant_raw = '0;
        if (state == LOCKED) begin
            grant_raw[PORT_LSU] = p0_valid;
        end else if (p1_valid && (wait_cnt == WAIT_MAX || !p0_valid)) begin
            grant_raw[PORT_IF] = 1'b1;
        end else begin
            grant_raw[PORT_LSU] = p0_valid;
        end
    end

    // Count IF stall cycles in IDLE; frozen while the LSU holds the lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant[PORT_IF] || !p1_valid) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

`endif

    // No access may be granted while reset is held.
    assign grant = reset_n ? grant_raw : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM (comb read, posedge write) between the LSU
// (port 0) and instruction fetch (port 1). One access per cycle, registered
// one-cycle response, optional LSU bus lock for read-modify-write.
// Build macro: MEM_ARB_RR_EN selects round-robin idle arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int MAX_WAIT = 4,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mem_port_arbiter_if.slave    bus,
    output logic                 ram_write_en,
    output logic [AW-1:0]        ram_addr,
    output logic [WIDTH-1:0]     ram_data_i,
    input  logic [WIDTH-1:0]     ram_data_o
);

    arb_state_t state;
    grant_t     grant;

    mem_arb_grant #(
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .clock    (clock),
        .reset_n  (reset_n),
        .state    (state),
        .p0_valid (bus.p0_valid),
        .p1_valid (bus.p1_valid),
        .grant    (grant)
    );

    assign bus.p0_ready = grant[PORT_LSU];
    assign bus.p1_ready = grant[PORT_IF];

    // RAM mux: LSU fields by default, IF address when IF is granted.
    always_comb begin
        ram_addr     = bus.p0_addr;
        ram_data_i   = bus.p0_wdata;
        ram_write_en = grant[PORT_LSU] && bus.p0_we;
        if (grant[PORT_IF]) begin
            ram_addr = bus.p1_addr;
        end
    end

    // Lock FSM: each LSU accept decides whether the lock is held for the next one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (grant[PORT_LSU]) begin
            state <= bus.p0_lock ? LOCKED : IDLE;
        end
    end

    // Response registers: rvalid pulses after every accept, rdata only on reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.p0_rvalid <= 1'b0;
            bus.p0_rdata  <= '0;
            bus.p1_rvalid <= 1'b0;
            bus.p1_rdata  <= '0;
        end else begin
            bus.p0_rvalid <= grant[PORT_LSU];
            bus.p1_rvalid <= grant[PORT_IF];
            if (grant[PORT_LSU] && !bus.p0_we) begin
                bus.p0_rdata <= ram_data_o;
            end
            if (grant[PORT_IF]) begin
                bus.p1_rdata <= ram_data_o;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a behavioural RAM.
// The reference model tracks lock/starvation/round-robin history as plain
// integers and the memory as an array. Honours MEM_ARB_RR_EN like the DUT.
module tb_mem_port_arbiter;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 64;
    localparam int AW       = 6;
    localparam int MAX_WAIT = 4;

    logic             clock;
    logic             reset_n;
    logic             ram_write_en;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_data_i;
    logic [WIDTH-1:0] ram_data_o;

    mem_port_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_port_arbiter #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT),
        .AW       (AW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_data_i   (ram_data_i),
        .ram_data_o   (ram_data_o)
    );

    // Behavioural single-port RAM: comb read, posedge write.
    logic [WIDTH-1:0] ram [DEPTH];
    assign ram_data_o = ram[ram_addr];
    always @(posedge clock) if (ram_write_en) ram[ram_addr] <= ram_data_i;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               m_locked;
    int               m_wcnt;
    int               m_last;
    bit               m_rv0, m_rv1;
    logic [WIDTH-1:0] m_rd0, m_rd1;
    bit               m_g0, m_g1;

    task automatic model_reset();
        m_locked = 0; m_wcnt = 0; m_last = 1;
        m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0;
        m_g0 = 0; m_g1 = 0;
    endtask

    // One clock cycle: drive new request unless one is still pending, check, advance model.
    task automatic step(input bit v0, input bit we, input bit lk, input int a0,
                        input logic [WIDTH-1:0] d0, input bit v1, input int a1);
        bit g0, g1;
        @(negedge clock);
        if (!(bus.p0_valid && !m_g0)) begin
            bus.p0_valid = v0; bus.p0_we = we; bus.p0_lock = lk;
            bus.p0_addr = AW'(a0); bus.p0_wdata = d0;
        end
        if (!(bus.p1_valid && !m_g1)) begin
            bus.p1_valid = v1; bus.p1_addr = AW'(a1);
        end
        #1;
        if (m_locked) begin
            g0 = bus.p0_valid; g1 = 0;
        end else begin
`ifdef MEM_ARB_RR_EN
            if (bus.p0_valid && bus.p1_valid) begin
                g0 = (m_last == 1); g1 = !g0;
            end else begin
                g0 = bus.p0_valid; g1 = bus.p1_valid;
            end
`else
            g1 = bus.p1_valid && (m_wcnt == MAX_WAIT || !bus.p0_valid);
            g0 = bus.p0_valid && !g1;
`endif
        end
        check_eq("p0_ready", bus.p0_ready, g0);
        check_eq("p1_ready", bus.p1_ready, g1);
        check_eq("ram_we", ram_write_en, g0 && bus.p0_we);
        if (g0) check_eq("ram_addr0", ram_addr, bus.p0_addr);
        if (g1) check_eq("ram_addr1", ram_addr, bus.p1_addr);
        if (g0 && bus.p0_we) check_eq("ram_wdata", ram_data_i, bus.p0_wdata);
        check_eq("p0_rvalid", bus.p0_rvalid, m_rv0);
        check_eq("p1_rvalid", bus.p1_rvalid, m_rv1);
        check_eq("p0_rdata", bus.p0_rdata, m_rd0);
        check_eq("p1_rdata", bus.p1_rdata, m_rd1);
        // advance the model to the next cycle
        m_rv0 = g0; m_rv1 = g1;
        if (g0 && !bus.p0_we) m_rd0 = ref_mem[bus.p0_addr];
        if (g1) m_rd1 = ref_mem[bus.p1_addr];
        if (g0 && bus.p0_we) ref_mem[bus.p0_addr] = bus.p0_wdata;
        if (!m_locked) begin
            if (g1 || !bus.p1_valid) m_wcnt = 0;
            else if (m_wcnt < MAX_WAIT) m_wcnt++;
        end
        if (g0) m_last = 0;
        else if (g1) m_last = 1;
        if (g0) m_locked = bus.p0_lock;
        m_g0 = g0; m_g1 = g1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
    endtask

    // Hold reset for n cycles with random request traffic, then release with valids low.
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset_n = 1'b0;
            bus.p0_valid = 1'($urandom_range(0, 1));
            bus.p0_we    = 1'($urandom_range(0, 1));
            bus.p1_valid = 1'($urandom_range(0, 1));
            #1;
            check_eq("rst_p0_rvalid", bus.p0_rvalid, 0);
            check_eq("rst_p1_rvalid", bus.p1_rvalid, 0);
            check_eq("rst_ram_we", ram_write_en, 0);
            check_eq("rst_p0_ready", bus.p0_ready, 0);
            check_eq("rst_p1_ready", bus.p1_ready, 0);
            check_eq("rst_p0_rdata", bus.p0_rdata, 0);
            check_eq("rst_p1_rdata", bus.p1_rdata, 0);
        end
        @(negedge clock);
        bus.p0_valid = 0; bus.p1_valid = 0; bus.p0_lock = 0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_step();
        bit v0, we, lk, v1;
        int a0, a1;
        v0 = ($urandom_range(0, 99) < 60);
        we = ($urandom_range(0, 99) < 45);
        lk = ($urandom_range(0, 99) < 15);
        v1 = ($urandom_range(0, 99) < 55);
        a0 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(1, 7);
        a1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(1, 7);
        step(v0, we, lk, a0, $urandom, v1, a1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        reset_n = 1'b0;
        bus.p0_valid = 0; bus.p0_we = 0; bus.p0_lock = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_valid = 0; bus.p1_addr = '0;
        model_reset();
        do_reset(2);

        // reset mid-traffic (addr 0 never written), then IF reads addr 0
        step(1, 1, 0, 7, 32'h1234_5678, 1, 6);
        step(1, 0, 1, 7, '0, 1, 6);
        do_reset(3);
        step(0, 0, 0, 0, '0, 1, 0);
        idle(1);
        check_eq("t1_rdata0", bus.p1_rdata, 0);

        // single-port write then read of addr 5
        step(1, 1, 0, 5, 32'hDEAD_BEEF, 0, 0);
        step(1, 0, 0, 5, '0, 0, 0);
        idle(1);
        check_eq("t2_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
        idle(1);

        // continuous conflict
        for (int i = 0; i < 15; i++) step(1, 0, 0, i + 1, '0, 1, 20 + i);
        idle(2);

        // lock: locked read of 9, unlocking write of 9, IF wants 9 throughout
        step(1, 0, 1, 9, '0, 1, 9);
        step(1, 1, 0, 9, 32'hA5A5_0009, 1, 9);
        step(0, 0, 0, 0, '0, 1, 9);
        idle(2);
        check_eq("t5_rdata", bus.p1_rdata, 32'hA5A5_0009);

        // write -> read hazard on addr 3
        step(1, 1, 0, 3, 32'h55, 0, 0);
        step(0, 0, 0, 0, '0, 1, 3);
        idle(1);
        check_eq("t6_rdata", bus.p1_rdata, 32'h55);

        // random traffic with one reset in the middle
        for (int i = 0; i < 1500; i++) rand_step();
        do_reset(2);
        for (int i = 0; i < 1500; i++) rand_step();
        idle(3);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
